// File: rtl/mem_seq_pkg.sv
// Shared types and defaults for the systolic-array BRAM sequencer.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCalc   = 3'd1,
        StSave   = 3'd2,
        StLoad   = 3'd3,
        StSacalc = 3'd4,
        StDone   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        MODE_AS   = 2'd0,
        MODE_SA   = 2'd1,
        MODE_ASE  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int unsigned STRIDE_A_DEF  = 64;
    localparam int unsigned STRIDE_SE_DEF = 32;

endpackage

// File: rtl/mem_seq_counter.sv
// Phase/line counter: phase wraps every ARRAY_N cycles and carries into line.
module mem_seq_counter #(
    parameter int unsigned PH_W   = 2,
    parameter int unsigned LINE_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [PH_W-1:0]   o_ph,
    output logic [LINE_W-1:0] o_line,
    output logic              o_ph_wrap
);

    logic [PH_W-1:0]   r_ph;
    logic [LINE_W-1:0] r_line;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_ph   <= '0;
            r_line <= '0;
        end else if (i_en) begin
            // ARRAY_N is a power of two, so the phase wraps by overflow
            r_ph <= r_ph + 1'b1;
            if (r_ph == '1) begin
                r_line <= r_line + 1'b1;
            end
        end
    end

    assign o_ph      = r_ph;
    assign o_line    = r_line;
    assign o_ph_wrap = (r_ph == '1);

endmodule

// File: rtl/mem_seq_ctrl.sv
// BRAM address/enable sequencer for AS, SA and AS+E passes through the systolic array.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int unsigned ARRAY_N   = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DIM_W     = 11,
    parameter int unsigned STRIDE_A  = STRIDE_A_DEF,
    parameter int unsigned STRIDE_SE = STRIDE_SE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic [ADDR_W-1:0] BASE_ADDR_S,
    input  logic [ADDR_W-1:0] BASE_ADDR_HASH,
    input  logic [ADDR_W-1:0] BASE_ADDR_B,
    input  logic [DIM_W-1:0]  MATRIX_SIZE,
    input  logic              HASH_ready,
    input  logic [DATA_W-1:0] bram_data_sb,
    input  logic [DATA_W-1:0] bram_data_HASH,
    input  logic [DATA_W-1:0] bram_data_sb_2,
    output logic [ADDR_W-1:0] addr_sb,
    output logic [ADDR_W-1:0] addr_HASH,
    output logic [ADDR_W-1:0] addr_sb_2,
    output logic              wen_sb,
    output logic              wen_HASH,
    output logic              wen_sb_2,
    output logic [DATA_W-1:0] data_left,
    output logic [DATA_W-1:0] data_right,
    output logic [DATA_W-1:0] data_adder,
    output logic              systolic_state,
    output logic              systolic_mode,
    output logic              systolic_enable,
    output logic              transposition_select,
    output logic              transposition_rst_sync,
    output logic              busy,
    output logic              done,
    output logic [2:0]        current_state
);

    localparam int unsigned PH_W   = $clog2(ARRAY_N);
    localparam int unsigned LINE_W = DIM_W + 1;
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(ARRAY_N / 2);

    state_e            r_state;
    mode_e             r_mode;
    logic [ADDR_W-1:0] r_base_s, r_base_h, r_base_b;
    logic [DIM_W-1:0]  r_size;
    logic [ADDR_W-1:0] r_pa, r_pse;
    logic              r_busy, r_done, r_tsel, r_trs;

    logic [PH_W-1:0]   w_ph, w_off_rev1, w_off_rev2;
    logic [LINE_W-1:0] w_line, w_size_l, w_line_lo, w_line_hi;
    logic              w_ph_wrap, w_active, w_accept, w_cnt_clr, w_sac_win;
    logic              w_calc_end, w_save_end, w_load_end, w_sac_end;
    logic [ADDR_W-1:0] w_line_a, w_line_se, w_ph_pa, w_ph_pse, w_save_off, w_rel_se;

    mem_seq_counter #(
        .PH_W   (PH_W),
        .LINE_W (LINE_W)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_cnt_clr),
        .i_en      (HASH_ready),
        .o_ph      (w_ph),
        .o_line    (w_line),
        .o_ph_wrap (w_ph_wrap)
    );

    assign w_size_l   = LINE_W'(r_size);
    assign w_line_lo  = LINE_W'(ARRAY_N);
    assign w_line_hi  = w_size_l + LINE_W'(ARRAY_N);
    assign w_active   = (r_state == StCalc) || (r_state == StSave) ||
                        (r_state == StLoad) || (r_state == StSacalc);
    assign w_accept   = (r_state == StIdle) && start && !abort && (mode != MODE_RSVD);

    // End-of-phase flags only fire on advancing cycles; a stall holds everything.
    assign w_calc_end = (r_state == StCalc) && HASH_ready && w_ph_wrap && (w_line == w_size_l);
    assign w_save_end = (r_state == StSave) && HASH_ready && w_ph_wrap &&
                        (w_line == LINE_W'(ARRAY_N - 1));
    assign w_load_end = (r_state == StLoad) && HASH_ready && w_ph_wrap;
    assign w_sac_end  = (r_state == StSacalc) && HASH_ready && w_ph_wrap && (w_line == w_line_hi);
    assign w_cnt_clr  = !w_active || abort || w_calc_end || w_save_end || w_load_end || w_sac_end;

    assign w_off_rev1 = PH_W'(ARRAY_N - 1) - w_ph;
    assign w_off_rev2 = PH_W'(ARRAY_N - 2) - w_ph;
    assign w_line_a   = ADDR_W'(w_line) * ADDR_W'(STRIDE_A);
    assign w_line_se  = ADDR_W'(w_line) * ADDR_W'(STRIDE_SE);
    assign w_ph_pa    = ADDR_W'(w_ph) * r_pa;
    assign w_ph_pse   = ADDR_W'(w_ph) * r_pse;
    assign w_save_off = ADDR_W'(w_off_rev2) * ADDR_W'(2 * STRIDE_A);
    assign w_rel_se   = (ADDR_W'(w_line) - ADDR_W'(ARRAY_N)) * ADDR_W'(STRIDE_SE);

    // First and last result lines are half lines because of the array skew.
    assign w_sac_win  = (w_line >= w_line_lo) && (w_line <= w_line_hi) &&
                        !((w_line == w_line_lo) && (w_ph < PH_HALF)) &&
                        !((w_line == w_line_hi) && (w_ph >= PH_HALF));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_mode   <= MODE_AS;
            r_base_s <= '0;
            r_base_h <= '0;
            r_base_b <= '0;
            r_size   <= '0;
            r_pa     <= '0;
            r_pse    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tsel   <= 1'b1;
            r_trs    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_trs  <= w_accept;
            if (r_busy && HASH_ready && !abort && (w_ph == '0)) begin
                r_tsel <= ~r_tsel;
            end
            if (abort) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (w_accept) begin
                            r_mode   <= mode_e'(mode);
                            r_base_s <= BASE_ADDR_S;
                            r_base_h <= BASE_ADDR_HASH;
                            r_base_b <= BASE_ADDR_B;
                            r_size   <= MATRIX_SIZE;
                            r_pa     <= ADDR_W'(MATRIX_SIZE) * ADDR_W'(STRIDE_A);
                            r_pse    <= ADDR_W'(MATRIX_SIZE) * ADDR_W'(STRIDE_SE);
                            r_busy   <= 1'b1;
                            r_state  <= (mode == MODE_SA) ? StLoad : StCalc;
                        end
                    end
                    StCalc:   if (w_calc_end) r_state <= StSave;
                    StLoad:   if (w_load_end) r_state <= StSacalc;
                    StSave, StSacalc: begin
                        if (w_save_end || w_sac_end) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    StDone:   r_state <= StIdle;
                    default:  r_state <= StIdle;
                endcase
            end
        end
    end

    always_comb begin
        addr_sb        = '0;
        addr_HASH      = '0;
        addr_sb_2      = '0;
        wen_sb_2       = 1'b0;
        data_left      = '0;
        data_right     = '0;
        data_adder     = '0;
        systolic_state = 1'b0;
        unique case (r_state)
            StCalc: begin
                addr_HASH      = r_base_h + w_line_a + w_ph_pa;
                addr_sb        = r_base_s + w_line_se + w_ph_pse;
                data_left      = bram_data_HASH;
                data_right     = bram_data_sb;
                systolic_state = 1'b1;
            end
            StSave: begin
                addr_sb    = r_base_b + w_save_off;
                addr_sb_2  = r_base_b + w_save_off;
                wen_sb_2   = HASH_ready && (w_line == LINE_W'(ARRAY_N - 1));
                data_adder = (r_mode == MODE_ASE) ? bram_data_sb_2 : bram_data_sb;
            end
            StLoad: begin
                addr_sb    = r_base_s + ADDR_W'(w_off_rev1) * r_pse;
                data_right = bram_data_sb;
            end
            StSacalc: begin
                addr_HASH      = r_base_h + w_line_a + w_ph_pa;
                addr_sb_2      = r_base_b + w_rel_se + w_ph_pse;
                wen_sb_2       = HASH_ready && w_sac_win;
                data_left      = bram_data_HASH;
                systolic_state = 1'b1;
            end
            default: ;
        endcase
    end

    assign wen_sb                 = 1'b0;
    assign wen_HASH               = 1'b0;
    assign systolic_mode          = r_busy && (r_mode != MODE_SA);
    assign systolic_enable        = r_busy && HASH_ready;
    assign transposition_select   = r_tsel;
    assign transposition_rst_sync = r_trs;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign current_state          = r_state;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl with ARRAY_N=4 and default strides.
module tb_mem_seq_ctrl;

    localparam logic [31:0] BH = 32'h1000_0000;
    localparam logic [31:0] BS = 32'h2000_0000;
    localparam logic [31:0] BB = 32'h3000_0000;
    localparam logic [63:0] H_VAL  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] SB_VAL = 64'h5B5B_0000_5B5B_0001;
    localparam logic [63:0] E_VAL  = 64'hE0E0_1234_E0E0_5678;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, HASH_ready;
    logic [1:0]  mode;
    logic [31:0] BASE_ADDR_S, BASE_ADDR_HASH, BASE_ADDR_B;
    logic [10:0] MATRIX_SIZE;
    logic [63:0] bram_data_sb, bram_data_HASH, bram_data_sb_2;
    logic [31:0] addr_sb, addr_HASH, addr_sb_2;
    logic        wen_sb, wen_HASH, wen_sb_2;
    logic [63:0] data_left, data_right, data_adder;
    logic        systolic_state, systolic_mode, systolic_enable;
    logic        transposition_select, transposition_rst_sync;
    logic        busy, done;
    logic [2:0]  current_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_seq_ctrl dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .mode                   (mode),
        .abort                  (abort),
        .BASE_ADDR_S            (BASE_ADDR_S),
        .BASE_ADDR_HASH         (BASE_ADDR_HASH),
        .BASE_ADDR_B            (BASE_ADDR_B),
        .MATRIX_SIZE            (MATRIX_SIZE),
        .HASH_ready             (HASH_ready),
        .bram_data_sb           (bram_data_sb),
        .bram_data_HASH         (bram_data_HASH),
        .bram_data_sb_2         (bram_data_sb_2),
        .addr_sb                (addr_sb),
        .addr_HASH              (addr_HASH),
        .addr_sb_2              (addr_sb_2),
        .wen_sb                 (wen_sb),
        .wen_HASH               (wen_HASH),
        .wen_sb_2               (wen_sb_2),
        .data_left              (data_left),
        .data_right             (data_right),
        .data_adder             (data_adder),
        .systolic_state         (systolic_state),
        .systolic_mode          (systolic_mode),
        .systolic_enable        (systolic_enable),
        .transposition_select   (transposition_select),
        .transposition_rst_sync (transposition_rst_sync),
        .busy                   (busy),
        .done                   (done),
        .current_state          (current_state)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Start is sampled on the next edge; afterwards the bench sits in cycle 1 of the pass.
    task automatic launch(input logic [1:0] m, input int unsigned size);
        mode        = m;
        MATRIX_SIZE = 11'(size);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; HASH_ready = 1'b1; mode = 2'd0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (current_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", current_state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (addr_HASH !== 32'h0) begin errors++; $display("FAIL reset_addr_HASH got %h exp 0", addr_HASH); end
        checks++; if (addr_sb !== 32'h0) begin errors++; $display("FAIL reset_addr_sb got %h exp 0", addr_sb); end
        checks++; if (addr_sb_2 !== 32'h0) begin errors++; $display("FAIL reset_addr_sb_2 got %h exp 0", addr_sb_2); end
        checks++; if (transposition_select !== 1'b1) begin errors++; $display("FAIL reset_tsel got %b exp 1", transposition_select); end
        checks++; if (systolic_enable !== 1'b0) begin errors++; $display("FAIL reset_sys_en got %b exp 0", systolic_enable); end
        // Reserved mode and abort while idle are both ignored
        mode = 2'd3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0; mode = 2'd0;
        checks++; if (current_state !== 3'd0) begin errors++; $display("FAIL rsvd_mode_state got %0d exp 0", current_state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsvd_mode_busy got %b exp 0", busy); end
    endtask

    task automatic test_as();
        int cyc, wen_cnt, done_cyc;
        logic busy_at_done;
        launch(2'd0, 8);
        cyc = 1; wen_cnt = 0; done_cyc = 0; busy_at_done = 1'b1;
        checks++; if (current_state !== 3'd1) begin errors++; $display("FAIL as_first_state got %0d exp 1", current_state); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL as_busy got %b exp 1", busy); end
        checks++; if (transposition_rst_sync !== 1'b1) begin errors++; $display("FAIL as_trs got %b exp 1", transposition_rst_sync); end
        checks++; if (systolic_mode !== 1'b1) begin errors++; $display("FAIL as_sys_mode got %b exp 1", systolic_mode); end
        while (cyc < 200 && done_cyc == 0) begin
            if (wen_sb_2 === 1'b1) wen_cnt++;
            if (cyc == 15) begin
                checks++; if (addr_HASH !== BH + 32'd1216) begin errors++; $display("FAIL as_addr_HASH_l3p2 got %h exp %h", addr_HASH, BH + 32'd1216); end
                checks++; if (addr_sb !== BS + 32'd608) begin errors++; $display("FAIL as_addr_sb_l3p2 got %h exp %h", addr_sb, BS + 32'd608); end
                checks++; if (data_left !== H_VAL) begin errors++; $display("FAIL as_data_left got %h exp %h", data_left, H_VAL); end
            end
            if (cyc == 37) begin
                checks++; if (current_state !== 3'd2) begin errors++; $display("FAIL as_save_state got %0d exp 2", current_state); end
                checks++; if (addr_sb !== BB + 32'd256) begin errors++; $display("FAIL as_save_addr got %h exp %h", addr_sb, BB + 32'd256); end
                checks++; if (data_adder !== SB_VAL) begin errors++; $display("FAIL as_data_adder got %h exp %h", data_adder, SB_VAL); end
            end
            if (cyc == 20) begin start = 1'b1; mode = 2'd1; end
            if (cyc == 21) begin start = 1'b0; mode = 2'd0; end
            tick(); cyc++;
            if (done === 1'b1) begin done_cyc = cyc; busy_at_done = busy; end
        end
        checks++; if (done_cyc !== 53) begin errors++; $display("FAIL as_done_cycle got %0d exp 53", done_cyc); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL as_busy_at_done got %b exp 0", busy_at_done); end
        checks++; if (wen_cnt !== 4) begin errors++; $display("FAIL as_wen_count got %0d exp 4", wen_cnt); end
        checks++; if (transposition_select !== 1'b0) begin errors++; $display("FAIL as_tsel got %b exp 0", transposition_select); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL as_done_pulse got %b exp 0", done); end
        checks++; if (current_state !== 3'd0) begin errors++; $display("FAIL as_back_idle got %0d exp 0", current_state); end
    endtask

    task automatic test_sa();
        logic [31:0] load_exp [4];
        int cyc, wen_cnt, done_cyc, first_wen, last_wen;
        logic [31:0] first_addr;
        load_exp = '{BS + 32'd384, BS + 32'd256, BS + 32'd128, BS};
        launch(2'd1, 4);
        cyc = 1; wen_cnt = 0; done_cyc = 0; first_wen = 0; last_wen = 0; first_addr = '0;
        checks++; if (current_state !== 3'd3) begin errors++; $display("FAIL sa_load_state got %0d exp 3", current_state); end
        while (cyc < 200 && done_cyc == 0) begin
            if (cyc <= 4) begin
                checks++; if (addr_sb !== load_exp[cyc-1]) begin errors++; $display("FAIL sa_load_addr%0d got %h exp %h", cyc, addr_sb, load_exp[cyc-1]); end
            end
            if (cyc == 5) begin
                checks++; if (current_state !== 3'd4) begin errors++; $display("FAIL sa_sacalc_state got %0d exp 4", current_state); end
            end
            if (cyc == 10) begin
                checks++; if (systolic_mode !== 1'b0) begin errors++; $display("FAIL sa_sys_mode got %b exp 0", systolic_mode); end
            end
            if (wen_sb_2 === 1'b1) begin
                wen_cnt++;
                if (first_wen == 0) begin first_wen = cyc; first_addr = addr_sb_2; end
                last_wen = cyc;
            end
            tick(); cyc++;
            if (done === 1'b1) done_cyc = cyc;
        end
        checks++; if (wen_cnt !== 16) begin errors++; $display("FAIL sa_wen_count got %0d exp 16", wen_cnt); end
        checks++; if (first_wen !== 23) begin errors++; $display("FAIL sa_first_wen got %0d exp 23", first_wen); end
        checks++; if (last_wen !== 38) begin errors++; $display("FAIL sa_last_wen got %0d exp 38", last_wen); end
        checks++; if (first_addr !== BB + 32'd256) begin errors++; $display("FAIL sa_first_waddr got %h exp %h", first_addr, BB + 32'd256); end
        checks++; if (done_cyc !== 41) begin errors++; $display("FAIL sa_done_cycle got %0d exp 41", done_cyc); end
        tick();
    endtask

    task automatic test_ase();
        int cyc, done_cyc;
        launch(2'd2, 2);
        cyc = 1; done_cyc = 0;
        while (cyc < 200 && done_cyc == 0) begin
            if (cyc == 13) begin
                checks++; if (current_state !== 3'd2) begin errors++; $display("FAIL ase_save_state got %0d exp 2", current_state); end
                checks++; if (data_adder !== E_VAL) begin errors++; $display("FAIL ase_data_adder got %h exp %h", data_adder, E_VAL); end
                checks++; if (addr_sb_2 !== BB + 32'd256) begin errors++; $display("FAIL ase_addr_sb_2 got %h exp %h", addr_sb_2, BB + 32'd256); end
            end
            tick(); cyc++;
            if (done === 1'b1) done_cyc = cyc;
        end
        checks++; if (done_cyc !== 29) begin errors++; $display("FAIL ase_done_cycle got %0d exp 29", done_cyc); end
        tick();
    endtask

    task automatic test_stall();
        int cyc, done_cyc;
        launch(2'd0, 8);
        cyc = 1; done_cyc = 0;
        while (cyc < 200 && done_cyc == 0) begin
            if (cyc == 12) begin
                checks++; if (systolic_enable !== 1'b0) begin errors++; $display("FAIL stall_sys_en got %b exp 0", systolic_enable); end
            end
            if (cyc == 15) begin
                checks++; if (addr_HASH !== BH + 32'd640) begin errors++; $display("FAIL stall_addr_HASH got %h exp %h", addr_HASH, BH + 32'd640); end
                checks++; if (current_state !== 3'd1) begin errors++; $display("FAIL stall_state got %0d exp 1", current_state); end
            end
            if (cyc == 10) HASH_ready = 1'b0;
            if (cyc == 15) HASH_ready = 1'b1;
            tick(); cyc++;
            if (done === 1'b1) done_cyc = cyc;
        end
        checks++; if (done_cyc !== 58) begin errors++; $display("FAIL stall_done_cycle got %0d exp 58", done_cyc); end
        tick();
    endtask

    task automatic test_abort();
        int cyc, done_cyc;
        logic saw_done;
        launch(2'd0, 8);
        saw_done = 1'b0;
        repeat (4) begin tick(); if (done === 1'b1) saw_done = 1'b1; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        if (done === 1'b1) saw_done = 1'b1;
        checks++; if (current_state !== 3'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", current_state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (addr_HASH !== 32'h0) begin errors++; $display("FAIL abort_addr got %h exp 0", addr_HASH); end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", saw_done); end
        launch(2'd1, 4);
        cyc = 1; done_cyc = 0;
        while (cyc < 200 && done_cyc == 0) begin
            tick(); cyc++;
            if (done === 1'b1) done_cyc = cyc;
        end
        checks++; if (done_cyc !== 41) begin errors++; $display("FAIL abort_then_sa_done got %0d exp 41", done_cyc); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        launch(2'd1, 4);
        repeat (9) tick();
        checks++; if (current_state !== 3'd4) begin errors++; $display("FAIL rmid_pre_state got %0d exp 4", current_state); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (current_state !== 3'd0) begin errors++; $display("FAIL rmid_state got %0d exp 0", current_state); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (addr_HASH !== 32'h0 || addr_sb_2 !== 32'h0) begin errors++; $display("FAIL rmid_addr got %h/%h exp 0/0", addr_HASH, addr_sb_2); end
        saw_done = 1'b0;
        repeat (60) begin tick(); if (done === 1'b1) saw_done = 1'b1; end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rmid_no_done got %b exp 0", saw_done); end
    endtask

    initial begin
        BASE_ADDR_S = BS; BASE_ADDR_HASH = BH; BASE_ADDR_B = BB;
        MATRIX_SIZE = 11'd1;
        bram_data_sb = SB_VAL; bram_data_HASH = H_VAL; bram_data_sb_2 = E_VAL;
        test_reset();
        test_as();
        test_sa();
        test_ase();
        test_stall();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
